// File: rtl/sync_fifo_wconv.sv
// Single-clock width-converting FIFO built on a CAP-entry array of G-bit units.
// Define SYNC_FIFO_WCONV_FWFT_EN for a first-word fall-through read port; otherwise rd_data is registered.
module sync_fifo_wconv #(
  parameter  int unsigned W_WIDTH   = 32,
  parameter  int unsigned R_WIDTH   = 16,
  parameter  int unsigned W_DEPTH   = 80,
  parameter  int unsigned AF_THRESH = 4,
  localparam int unsigned G         = (W_WIDTH < R_WIDTH) ? W_WIDTH : R_WIDTH,
  localparam int unsigned WU        = W_WIDTH / G,
  localparam int unsigned RU        = R_WIDTH / G,
  localparam int unsigned CAP       = W_DEPTH * WU,
  localparam int unsigned LW        = $clog2(CAP + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [W_WIDTH-1:0] wr_data,
  output logic               wr_full,
  output logic               wr_almost_full,
  input  logic               rd_en,
  output logic [R_WIDTH-1:0] rd_data,
  output logic               rd_empty,
  output logic               rd_valid,
  output logic [LW-1:0]      level,
  output logic               overflow,
  output logic               underflow
);

  localparam int unsigned PW = (CAP > 1) ? $clog2(CAP) : 1;

  // Handshake: a write transfers on a rising edge when wr_en && !wr_full, a read when
  // rd_en && !rd_empty; both use pre-edge status, flush overrides both, and a request
  // against a blocked side is dropped and latched into the matching sticky error flag.

  logic [G-1:0]       mem_q [CAP];
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               wr_acc, rd_acc;
  logic [R_WIDTH-1:0] rd_word;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    if (s >= CAP) s = s - CAP;
    return s[PW-1:0];
  endfunction

  assign wr_full        = (CAP - 32'(level_q)) < WU;
  assign rd_empty       = 32'(level_q) < RU;
  assign wr_almost_full = (CAP - 32'(level_q)) < ((AF_THRESH + 1) * WU);
  assign level          = level_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;

  assign wr_acc = wr_en && !wr_full && !flush;
  assign rd_acc = rd_en && !rd_empty && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = ptr_add(wptr_q, WU);
      if (rd_acc) rptr_d = ptr_add(rptr_q, RU);
      level_d = LW'(32'(level_q) + (wr_acc ? WU : 32'd0) - (rd_acc ? RU : 32'd0));
      ovf_d   = ovf_q || (wr_en && wr_full);
      unf_d   = unf_q || (rd_en && rd_empty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is never reset; level alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned i = 0; i < WU; i++) begin
        mem_q[ptr_add(wptr_q, i)] <= wr_data[i*G +: G];
      end
    end
  end

  // Read units may straddle the array end when CAP is not a multiple of RU.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < RU; i++) begin
      rd_word[i*G +: G] = mem_q[ptr_add(rptr_q, i)];
    end
  end

`ifdef SYNC_FIFO_WCONV_FWFT_EN
  assign rd_data  = rd_empty ? '0 : rd_word;
  assign rd_valid = !rd_empty;
`else
  logic [R_WIDTH-1:0] rd_data_q;
  logic               rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= rd_word;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_wconv.sv
// Directed bench for sync_fifo_wconv: 32->16 at depth 80, 16->32 at depth 80 and 16->32 at depth 5.
// Adapts its read timing to SYNC_FIFO_WCONV_FWFT_EN.
module tb_sync_fifo_wconv;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  // dut_a: 32 -> 16, depth 80 (CAP 160)
  logic        a_flush, a_wr_en, a_rd_en;
  logic [31:0] a_wr_data;
  logic [15:0] a_rd_data;
  logic        a_wr_full, a_af, a_rd_empty, a_rd_valid, a_ovf, a_unf;
  logic [7:0]  a_level;

  // dut_b: 16 -> 32, depth 80 (CAP 80)
  logic        b_flush, b_wr_en, b_rd_en;
  logic [15:0] b_wr_data;
  logic [31:0] b_rd_data;
  logic        b_wr_full, b_af, b_rd_empty, b_rd_valid, b_ovf, b_unf;
  logic [6:0]  b_level;

  // dut_c: 16 -> 32, depth 5 (CAP 5, read words straddle the wrap)
  logic        c_flush, c_wr_en, c_rd_en;
  logic [15:0] c_wr_data;
  logic [31:0] c_rd_data;
  logic        c_wr_full, c_af, c_rd_empty, c_rd_valid, c_ovf, c_unf;
  logic [2:0]  c_level;

  sync_fifo_wconv #(.W_WIDTH(32), .R_WIDTH(16), .W_DEPTH(80), .AF_THRESH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .wr_full(a_wr_full), .wr_almost_full(a_af), .rd_en(a_rd_en), .rd_data(a_rd_data),
    .rd_empty(a_rd_empty), .rd_valid(a_rd_valid), .level(a_level),
    .overflow(a_ovf), .underflow(a_unf));

  sync_fifo_wconv #(.W_WIDTH(16), .R_WIDTH(32), .W_DEPTH(80), .AF_THRESH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .wr_full(b_wr_full), .wr_almost_full(b_af), .rd_en(b_rd_en), .rd_data(b_rd_data),
    .rd_empty(b_rd_empty), .rd_valid(b_rd_valid), .level(b_level),
    .overflow(b_ovf), .underflow(b_unf));

  sync_fifo_wconv #(.W_WIDTH(16), .R_WIDTH(32), .W_DEPTH(5), .AF_THRESH(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .wr_en(c_wr_en), .wr_data(c_wr_data),
    .wr_full(c_wr_full), .wr_almost_full(c_af), .rd_en(c_rd_en), .rd_data(c_rd_data),
    .rd_empty(c_rd_empty), .rd_valid(c_rd_valid), .level(c_level),
    .overflow(c_ovf), .underflow(c_unf));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [31:0] d);
    a_wr_en = 1'b1; a_wr_data = d;
    tick();
    a_wr_en = 1'b0;
  endtask

  // Returns the word the read handed over and rd_valid as seen for that word.
  task automatic a_read(output logic [15:0] d, output logic v);
`ifdef SYNC_FIFO_WCONV_FWFT_EN
    d = a_rd_data; v = a_rd_valid;
    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
`else
    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    d = a_rd_data; v = a_rd_valid;
`endif
  endtask

  task automatic b_write(input logic [15:0] d);
    b_wr_en = 1'b1; b_wr_data = d;
    tick();
    b_wr_en = 1'b0;
  endtask

  task automatic c_write(input logic [15:0] d);
    c_wr_en = 1'b1; c_wr_data = d;
    tick();
    c_wr_en = 1'b0;
  endtask

  initial begin
    logic [15:0] d16, lo, hi, last;
    logic [31:0] exp32, got32;
    logic        v;
    int          n;

    rst_n = 1'b0;
    a_flush = 0; a_wr_en = 0; a_rd_en = 0; a_wr_data = '0;
    b_flush = 0; b_wr_en = 0; b_rd_en = 0; b_wr_data = '0;
    c_flush = 0; c_wr_en = 0; c_rd_en = 0; c_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // reset state
    check("rst_level", 32'(a_level), 0);
    check("rst_empty", 32'(a_rd_empty), 1);
    check("rst_full", 32'(a_wr_full), 0);
    check("rst_af", 32'(a_af), 0);
    check("rst_valid", 32'(a_rd_valid), 0);
    check("rst_rd_data", 32'(a_rd_data), 0);
    check("rst_ovf", 32'(a_ovf), 0);
    check("rst_unf", 32'(a_unf), 0);
    check("rst_b_empty", 32'(b_rd_empty), 1);

    // one wide word out as two narrow words, low half first
    a_write(32'hBEEF_1234);
    check("w1_level", 32'(a_level), 2);
    check("w1_empty", 32'(a_rd_empty), 0);
    a_read(d16, v);
    check("r1_data", 32'(d16), 32'h1234);
    check("r1_valid", 32'(v), 1);
    check("r1_level", 32'(a_level), 1);
    a_read(d16, v);
    check("r2_data", 32'(d16), 32'hBEEF);
    check("r2_level", 32'(a_level), 0);
    check("r2_empty", 32'(a_rd_empty), 1);
    tick();
    check("r2_valid_drop", 32'(a_rd_valid), 0);

    // fill to capacity: almost-full from 76 words (level 152), full at 80 (level 160)
    for (int k = 0; k < 80; k++) begin
      lo = 16'(k);
      hi = 16'(k) ^ 16'hA5A5;
      a_write({hi, lo});
      exp_q.push_back(lo);
      exp_q.push_back(hi);
      n = k + 1;
      check("fill_level", 32'(a_level), 32'(2 * n));
      check("fill_af", 32'(a_af), (n >= 76) ? 1 : 0);
      check("fill_full", 32'(a_wr_full), (n == 80) ? 1 : 0);
    end
    a_write(32'hDEAD_DEAD);
    check("ovf_level", 32'(a_level), 160);
    check("ovf_flag", 32'(a_ovf), 1);
    check("ovf_full", 32'(a_wr_full), 1);

    last = '0;
    while (exp_q.size() > 0) begin
      last = exp_q.pop_front();
      a_read(d16, v);
      check("drain_data", 32'(d16), 32'(last));
    end
    check("drain_level", 32'(a_level), 0);
    check("drain_empty", 32'(a_rd_empty), 1);
    check("drain_ovf_sticky", 32'(a_ovf), 1);

    // read on empty: rejected, flagged, nothing else moves
    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    check("unf_flag", 32'(a_unf), 1);
    check("unf_level", 32'(a_level), 0);
    check("unf_valid", 32'(a_rd_valid), 0);
`ifdef SYNC_FIFO_WCONV_FWFT_EN
    check("unf_rd_data", 32'(a_rd_data), 0);
`else
    check("unf_rd_data", 32'(a_rd_data), 32'(last));
`endif
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("flush_unf", 32'(a_unf), 0);
    check("flush_ovf", 32'(a_ovf), 0);

    // flush beats a same-cycle write and read
    a_write(32'h0002_0001);
    a_write(32'h0004_0003);
    a_write(32'h0006_0005);
    check("pre_flush_level", 32'(a_level), 6);
    a_flush = 1'b1; a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 32'h7777_8888;
    tick();
    a_flush = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
    check("fl_level", 32'(a_level), 0);
    check("fl_empty", 32'(a_rd_empty), 1);
    check("fl_full", 32'(a_wr_full), 0);
    check("fl_valid", 32'(a_rd_valid), 0);
    a_write(32'h3333_4444);
    check("post_fl_level", 32'(a_level), 2);
    a_read(d16, v);
    check("post_fl_data", 32'(d16), 32'h4444);

    // narrow to wide: empty until both halves are in
    b_write(16'h1111);
    check("b_w1_empty", 32'(b_rd_empty), 1);
    check("b_w1_level", 32'(b_level), 1);
    b_write(16'h2222);
    check("b_w2_empty", 32'(b_rd_empty), 0);
`ifdef SYNC_FIFO_WCONV_FWFT_EN
    got32 = b_rd_data;
    b_rd_en = 1'b1;
    tick();
    b_rd_en = 1'b0;
`else
    b_rd_en = 1'b1;
    tick();
    b_rd_en = 1'b0;
    got32 = b_rd_data;
`endif
    check("b_rd_data", got32, 32'h2222_1111);
    check("b_rd_level", 32'(b_level), 0);

    // depth 5 stream: write every cycle, read every other cycle, level oscillates 1..2
    exp_q.delete();
    c_write(16'h0100);
    c_write(16'h0101);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0101);
    for (int j = 0; j < 20; j++) begin
      c_wr_en = 1'b1;
      c_wr_data = 16'h0100 + 16'(j + 2);
      c_rd_en = (j % 2 == 0);
      exp32 = '0;
      if (c_rd_en) begin
        lo = exp_q.pop_front();
        hi = exp_q.pop_front();
        exp32 = {hi, lo};
`ifdef SYNC_FIFO_WCONV_FWFT_EN
        check("c_stream_data", c_rd_data, exp32);
`endif
      end
      tick();
      exp_q.push_back(c_wr_data);
`ifndef SYNC_FIFO_WCONV_FWFT_EN
      if (c_rd_en) check("c_stream_data", c_rd_data, exp32);
`endif
      c_wr_en = 1'b0;
      c_rd_en = 1'b0;
      check("c_stream_level", 32'(c_level), (j % 2 == 0) ? 1 : 2);
    end
    lo = exp_q.pop_front();
    hi = exp_q.pop_front();
`ifdef SYNC_FIFO_WCONV_FWFT_EN
    got32 = c_rd_data;
    c_rd_en = 1'b1;
    tick();
    c_rd_en = 1'b0;
`else
    c_rd_en = 1'b1;
    tick();
    c_rd_en = 1'b0;
    got32 = c_rd_data;
`endif
    check("c_last_data", got32, {hi, lo});
    check("c_last_level", 32'(c_level), 0);
    check("c_no_ovf", 32'(c_ovf), 0);
    check("c_no_unf", 32'(c_unf), 0);

    // asynchronous reset mid-cycle
    a_write(32'hCAFE_F00D);
    c_write(16'h5555);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a_level", 32'(a_level), 0);
    check("arst_a_empty", 32'(a_rd_empty), 1);
    check("arst_a_rd_data", 32'(a_rd_data), 0);
    check("arst_c_level", 32'(c_level), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_a_level_hold", 32'(a_level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
